// File: rtl/hack_cpu_pkg.sv
// Shared FSM state type, Hack instruction field positions and jump codes for hack_cpu_mc.
package hack_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM_WR = 3'd4
  } state_e;

  // C-instruction fields sit at fixed low positions regardless of DATA_W.
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_HI = 5;
  localparam int DEST_LO = 3;
  localparam int JUMP_HI = 2;
  localparam int JUMP_LO = 0;

  localparam int DEST_A = 2;
  localparam int DEST_D = 1;
  localparam int DEST_M = 0;

  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

  // The instruction-type bit is always the MSB of the word.
  function automatic int type_bit(input int data_w);
    return data_w - 1;
  endfunction

endpackage

// File: rtl/hack_cpu_mc_alu.sv
// Combinational Hack ALU (zx/nx/zy/ny/f/no) at DATA_W bits with zero/negative flags.
module hack_alu_p #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              zx,
  input  logic              nx,
  input  logic              zy,
  input  logic              ny,
  input  logic              f,
  input  logic              no,
  output logic [DATA_W-1:0] out,
  output logic              zr,
  output logic              ng
);

  logic signed [DATA_W-1:0] xz, xn, yz, yn, fo;

  always_comb begin
    xz  = zx ? '0 : $signed(x);
    xn  = nx ? ~xz : xz;
    yz  = zy ? '0 : $signed(y);
    yn  = ny ? ~yz : yz;
    fo  = f ? (xn + yn) : (xn & yn);
    out = no ? ~fo : fo;
  end

  assign zr = (out == '0);
  assign ng = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with variable-latency fetch and req/ack data memory.
// Optional halt-loop detection is enabled by defining HACK_CPU_HALT_DETECT_EN.
module hack_cpu_mc
  import hack_cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] pc,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instruction,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] addressM,
  output logic [DATA_W-1:0] outM,
  input  logic [DATA_W-1:0] inM,
  input  logic              mem_ack,
  output logic              halted
);

  localparam int TYPE_BIT = type_bit(DATA_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, waddr_q, waddr_d, pc_inc;
  logic [DATA_W-1:0] a_q, a_d, d_q, d_d, ir_q, ir_d, mdr_q, mdr_d, outm_q, outm_d;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        dest, jump;
  logic              alu_zr, alu_ng, is_c, taken;

  assign is_c   = ir_q[TYPE_BIT];
  assign dest   = ir_q[DEST_HI:DEST_LO];
  assign jump   = ir_q[JUMP_HI:JUMP_LO];
  assign pc_inc = pc_q + ADDR_W'(1);

  hack_alu_p #(.DATA_W(DATA_W)) u_alu (
    .x  (d_q),
    .y  (ir_q[A_BIT] ? mdr_q : a_q),
    .zx (ir_q[COMP_HI]),
    .nx (ir_q[COMP_HI-1]),
    .zy (ir_q[COMP_HI-2]),
    .ny (ir_q[COMP_HI-3]),
    .f  (ir_q[COMP_LO+1]),
    .no (ir_q[COMP_LO]),
    .out(alu_out),
    .zr (alu_zr),
    .ng (alu_ng)
  );

  always_comb begin
    case (jump)
      JNULL:   taken = 1'b0;
      JGT:     taken = !alu_zr && !alu_ng;
      JEQ:     taken = alu_zr;
      JGE:     taken = !alu_ng;
      JLT:     taken = alu_ng;
      JNE:     taken = !alu_zr;
      JLE:     taken = alu_zr || alu_ng;
      JMP:     taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    outm_d  = outm_q;
    waddr_d = waddr_q;
    case (state_q)
      ST_FETCH: begin
        if (!halted && instr_valid) begin
          ir_d    = instruction;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!is_c) begin
          a_d     = ir_q;
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end else begin
          state_d = ir_q[A_BIT] ? ST_MEM_RD : ST_EXEC;
        end
      end
      ST_MEM_RD: begin
        if (mem_ack) begin
          mdr_d   = inM;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Jump target and write address both use A as it was before this cycle.
        if (dest[DEST_D]) d_d = alu_out;
        if (dest[DEST_A]) a_d = alu_out;
        pc_d = taken ? a_q[ADDR_W-1:0] : pc_inc;
        if (dest[DEST_M]) begin
          outm_d  = alu_out;
          waddr_d = a_q[ADDR_W-1:0];
          state_d = ST_MEM_WR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM_WR: begin
        if (mem_ack) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      outm_q  <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      outm_q  <= outm_d;
      waddr_q <= waddr_d;
    end
  end

`ifdef HACK_CPU_HALT_DETECT_EN
  logic              halted_q, halted_d, last_a_q, last_a_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d, pc_m1;

  assign pc_m1 = pc_q - ADDR_W'(1);

  // "@L; 0;JMP" idle loop: taken jump right after an A-instruction that points at itself.
  always_comb begin
    halted_d  = halted_q;
    last_a_d  = last_a_q;
    last_pc_d = last_pc_q;
    if (state_q == ST_DECODE && !is_c) begin
      last_a_d  = 1'b1;
      last_pc_d = pc_q;
    end
    if (state_q == ST_EXEC) begin
      last_a_d = 1'b0;
      if (taken && last_a_q && last_pc_q == pc_m1 && a_q[ADDR_W-1:0] == pc_m1) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      halted_q  <= 1'b0;
      last_a_q  <= 1'b0;
      last_pc_q <= '0;
    end else begin
      halted_q  <= halted_d;
      last_a_q  <= last_a_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign fetch_req  = (state_q == ST_FETCH) && !halted && !reset;
  assign mem_rd_req = (state_q == ST_MEM_RD);
  assign mem_wr_req = (state_q == ST_MEM_WR);
  assign addressM   = (state_q == ST_MEM_WR) ? waddr_q : a_q[ADDR_W-1:0];
  assign outM       = outm_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Testbench for hack_cpu_mc: directed programs plus random programs checked against an ISA-level model.
`timescale 1ns/1ps
module tb_hack_cpu_mc;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset, instr_valid, mem_ack;
  logic [DW-1:0] instruction, inM;
  logic          fetch_req, mem_rd_req, mem_wr_req, halted;
  logic [AW-1:0] pc, addressM;
  logic [DW-1:0] outM;

  always #5 clock = ~clock;

  hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .pc(pc),
    .instr_valid(instr_valid), .instruction(instruction),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .addressM(addressM),
    .outM(outM), .inM(inM), .mem_ack(mem_ack), .halted(halted)
  );

  logic [DW-1:0] rom [16];
  logic [DW-1:0] ram [16];
  logic [DW-1:0] m_ram [16];
  logic [DW-1:0] m_a, m_d;
  int            m_pc;
  logic [AW-1:0]    exp_rd_q [$];
  logic [AW+DW-1:0] exp_wr_q [$];

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, nfetch = 0, fetch_limit = 0, last_acc_cyc = 0, wr_cycles = 0;
  int   rd_wait_fix = 0, wr_wait_fix = 0, wait_left = 0, lat = 0;
  bit   iv_rand = 0;
  logic rst_next = 1'b1;
  logic prev_rd = 0, prev_wr = 0, prev_ack = 0, prev_rst = 1;

  logic [5:0] comps [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                             6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                             6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] ai(input int v);
    return {1'b0, 15'(v)};
  endfunction

  function automatic logic [DW-1:0] ci(input logic a, input logic [5:0] c, input logic [2:0] d,
                                       input logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  // Hack computations by mnemonic, y is A or M.
  function automatic logic [DW-1:0] hack_comp(input logic [5:0] c, input logic [DW-1:0] d,
                                              input logic [DW-1:0] y);
    case (c)
      6'b101010: return 0;
      6'b111111: return 1;
      6'b111010: return -1;
      6'b001100: return d;
      6'b110000: return y;
      6'b001101: return ~d;
      6'b110001: return ~y;
      6'b001111: return -d;
      6'b110011: return -y;
      6'b011111: return d + 1;
      6'b110111: return y + 1;
      6'b001110: return d - 1;
      6'b110010: return y - 1;
      6'b000010: return d + y;
      6'b010011: return d - y;
      6'b000111: return y - d;
      6'b000000: return d & y;
      6'b010101: return d | y;
      default:   return 'x;
    endcase
  endfunction

  task automatic model_exec(input logic [DW-1:0] ins);
    logic [DW-1:0] y, r, olda;
    logic          tk;
    if (!ins[DW-1]) begin
      m_a  = ins;
      m_pc = (m_pc + 1) % 16;
      return;
    end
    olda = m_a;
    if (ins[12]) begin
      y = m_ram[olda[AW-1:0]];
      exp_rd_q.push_back(olda[AW-1:0]);
    end else y = m_a;
    r  = hack_comp(ins[11:6], m_d, y);
    tk = (ins[2] && $signed(r) < 0) || (ins[1] && r == 0) || (ins[0] && $signed(r) > 0);
    if (ins[3]) begin
      m_ram[olda[AW-1:0]] = r;
      exp_wr_q.push_back({olda[AW-1:0], r});
    end
    if (ins[4]) m_d = r;
    if (ins[5]) m_a = r;
    m_pc = tk ? int'(olda[AW-1:0]) : (m_pc + 1) % 16;
  endtask

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, 3));
  endfunction

  // One clock: apply reset, sample outputs, drive the ROM/RAM responders, score events.
  task automatic tick();
    logic acc, rd_done, wr_done, new_req;
    @(negedge clock);
    reset = rst_next;
    #1;
    cyc++;
    if (!prev_rst) begin
      chk("one_req", 32'(mem_rd_req & mem_wr_req), 0);
      if (prev_rd && !prev_ack) chk("rd_held", 32'(mem_rd_req), 1);
      if (prev_wr && !prev_ack) chk("wr_held", 32'(mem_wr_req), 1);
    end
    if (mem_wr_req) wr_cycles++;
    if (fetch_req) begin
      instr_valid = (nfetch < fetch_limit) && (!iv_rand || $urandom_range(0, 2) != 0);
      instruction = rom[pc];
    end else begin
      instr_valid = 1'($urandom_range(0, 1));
      instruction = DW'($urandom);
    end
    if (mem_rd_req || mem_wr_req) begin
      new_req = !((prev_rd || prev_wr) && !prev_ack) || prev_rst;
      if (new_req) wait_left = mem_rd_req ? pick(rd_wait_fix) : pick(wr_wait_fix);
      mem_ack = (wait_left == 0);
      if (wait_left > 0) wait_left--;
    end else begin
      mem_ack = 1'($urandom_range(0, 1));
    end
    inM = mem_rd_req ? ram[addressM] : DW'($urandom);
    acc     = fetch_req && instr_valid;
    rd_done = mem_rd_req && mem_ack;
    wr_done = mem_wr_req && mem_ack;
    if (reset) begin
      m_pc = 0; m_a = 0; m_d = 0; nfetch = 0;
      exp_rd_q.delete();
      exp_wr_q.delete();
      for (int i = 0; i < 16; i++) m_ram[i] = ram[i];
    end else begin
      if (acc) begin
        chk("fetch_pc", 32'(pc), m_pc);
        nfetch++;
        last_acc_cyc = cyc;
        model_exec(rom[pc]);
      end
      if (rd_done) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 32'(addressM), 32'hFFFF_FFFF);
        else chk("rd_addr", 32'(addressM), 32'(exp_rd_q.pop_front()));
      end
      if (wr_done) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", {12'b0, addressM, outM}, 32'hFFFF_FFFF);
        else chk("wr_addr_data", {12'b0, addressM, outM}, 32'(exp_wr_q.pop_front()));
        ram[addressM] = outM;
      end
    end
    prev_rd  = mem_rd_req;
    prev_wr  = mem_wr_req;
    prev_ack = mem_ack;
    prev_rst = reset;
  endtask

  // Let n instructions in total be fetched and run until the CPU asks for the next one.
  task automatic run_retire(input int n, input int budget, output int latency);
    int k;
    k = 0;
    fetch_limit = n;
    do begin
      tick();
      k++;
    end while (!(nfetch == n && fetch_req && cyc > last_acc_cyc &&
                 exp_rd_q.size() == 0 && exp_wr_q.size() == 0) && k < budget);
    chk("retire_in_budget", 32'(k < budget), 1);
    latency = cyc - last_acc_cyc;
  endtask

  task automatic restart();
    fetch_limit = 0;
    rst_next = 1'b1;
    tick();
    tick();
    rst_next = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instruction = '0; inM = '0; mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin rom[i] = '0; ram[i] = '0; end

    // Reset values and a single A-instruction
    rom[0] = ai(5);
    tick(); tick();
    chk("rst_fetch_req", 32'(fetch_req), 0);
    chk("rst_rd_req", 32'(mem_rd_req), 0);
    chk("rst_wr_req", 32'(mem_wr_req), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_addressM", 32'(addressM), 0);
    chk("rst_outM", 32'(outM), 0);
    chk("rst_halted", 32'(halted), 0);
    rst_next = 1'b0;
    run_retire(1, 20, lat);
    chk("a_latency", lat, 2);
    chk("a_pc", 32'(pc), 1);
    chk("a_value", 32'(addressM), 5);

    // Write with three wait states
    rom[0] = ai(3); rom[1] = ci(0, 6'b110000, 3'b010, 3'b000);
    rom[2] = ai(7); rom[3] = ci(0, 6'b001100, 3'b001, 3'b000);
    wr_wait_fix = 3;
    restart();
    run_retire(3, 40, lat);
    wr_cycles = 0;
    run_retire(4, 40, lat);
    chk("mwr_latency", lat, 7);
    chk("mwr_req_cycles", wr_cycles, 4);
    chk("mwr_pc", 32'(pc), 4);
    chk("mwr_outM", 32'(outM), 3);
    chk("mwr_ram7", 32'(ram[7]), 3);

    // Read-modify-write across the sign boundary, then D=M;JLT
    wr_wait_fix = 0;
    ram[10] = 16'h7FFF;
    rom[0] = ai(10); rom[1] = ci(1, 6'b110111, 3'b001, 3'b000); rom[2] = ci(1, 6'b110000, 3'b010, 3'b100);
    restart();
    run_retire(1, 20, lat);
    run_retire(2, 20, lat);
    chk("mplus1_latency", lat, 5);
    chk("mplus1_ram10", 32'(ram[10]), 32'h8000);
    run_retire(3, 20, lat);
    chk("dm_jlt_latency", lat, 4);
    chk("dm_jlt_pc", 32'(pc), 10);

    // Jump taken / not taken / AM=1;JMP uses old A
    rom[0] = ai(2); rom[1] = ci(0, 6'b101010, 3'b000, 3'b111);
    rom[2] = ai(0); rom[3] = ci(0, 6'b111010, 3'b010, 3'b100);
    restart();
    run_retire(4, 40, lat);
    chk("jlt_taken_pc", 32'(pc), 0);
    rom[0] = ci(0, 6'b101010, 3'b010, 3'b101);
    run_retire(5, 20, lat);
    chk("jne_not_taken_pc", 32'(pc), 1);
    rom[1] = ai(9); rom[2] = ci(0, 6'b111111, 3'b101, 3'b111);
    run_retire(7, 40, lat);
    chk("am_jmp_pc", 32'(pc), 9);
    chk("am_jmp_newA", 32'(addressM), 1);
    chk("am_jmp_ram9", 32'(ram[9]), 1);

    // pc wrap, then reset while a read is pending
    rom[0] = ai(15); rom[1] = ci(0, 6'b101010, 3'b000, 3'b111); rom[15] = ci(0, 6'b011111, 3'b010, 3'b000);
    restart();
    run_retire(3, 40, lat);
    chk("wrap_pc", 32'(pc), 0);
    rom[0] = ci(1, 6'b110000, 3'b010, 3'b000);
    rd_wait_fix = 10;
    fetch_limit = 4;
    begin
      int k;
      k = 0;
      while (!mem_rd_req && k < 20) begin tick(); k++; end
      chk("rd_req_seen", 32'(mem_rd_req), 1);
    end
    chk("rd_wait_addr", 32'(addressM), 15);
    fetch_limit = 0;
    rst_next = 1'b1;
    tick();
    rst_next = 1'b0;
    tick();
    chk("abort_rd_req", 32'(mem_rd_req), 0);
    chk("abort_pc", 32'(pc), 0);
    rd_wait_fix = 0;

    // Idle loop "@4; 0;JMP" at address 4
    for (int i = 0; i < 16; i++) rom[i] = '0;
    rom[0] = ai(4); rom[1] = ci(0, 6'b101010, 3'b000, 3'b111);
    rom[4] = ai(4); rom[5] = ci(0, 6'b101010, 3'b000, 3'b111);
    restart();
`ifdef HACK_CPU_HALT_DETECT_EN
    fetch_limit = 100;
    for (int i = 0; i < 40; i++) tick();
    chk("halt_halted", 32'(halted), 1);
    chk("halt_fetch_req", 32'(fetch_req), 0);
    chk("halt_nfetch", nfetch, 4);
    chk("halt_pc", 32'(pc), 4);
`else
    run_retire(10, 100, lat);
    chk("loop_pc", 32'(pc), 4);
    chk("loop_halted", 32'(halted), 0);
`endif

    // Random programs with random fetch and memory wait states
    iv_rand = 1; rd_wait_fix = -1; wr_wait_fix = -1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        ram[i] = DW'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          rom[i] = ai(int'($urandom_range(0, 32767)));
          if (rom[i][3:0] == 4'(i)) rom[i][3:0] = ~rom[i][3:0];
        end else begin
          rom[i] = ci(1'($urandom_range(0, 1)), comps[$urandom_range(0, 17)], 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
        end
      end
      restart();
      run_retire(50, 2000, lat);
      for (int i = 0; i < 16; i++) chk("rand_ram", 32'(ram[i]), 32'(m_ram[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
